// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM encoding, default width and clog2 helper for the serial adder
//   state_t : IDLE=0, RUN=1, DONE=2
//   ADD_W   : default operand width
//   clog2   : ceil(log2(v)) with a minimum of 1, used for counter sizing
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADD_W = 8;

    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ha_cell.sv
// ha_cell: combinational half adder
//   a, b : input bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder, one full-adder cell reused LSB-first over WIDTH cycles
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start           : request, accepted only in IDLE
//   a, b, cin       : operands and carry-in, captured on accepted start
//   busy            : high while bits are being processed
//   done            : one-cycle pulse when sum/cout are updated
//   sum, cout       : registered result, held until the next completion
module serial_add_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             c_reg;
    logic [CW-1:0]    cnt;
    logic             s0, c0, s1, c1;
    logic             carry_next, last;
    logic [WIDTH-1:0] acc_nxt;

    ha_cell ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s0), .c(c0));
    ha_cell ha1 (.a(s0),      .b(c_reg),   .s(s1), .c(c1));

    assign carry_next = c0 | c1;
    assign last       = cnt == CW'(WIDTH - 1);
    // shift form instead of a slice so WIDTH=1 elaborates cleanly
    assign acc_nxt    = (acc >> 1) | (WIDTH'(s1) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    c_reg <= cin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= acc_nxt;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    c_reg <= carry_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= acc_nxt;
                        cout  <= carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial adder controller. It time-shares a single full-adder cell, built from two half-adder cells, over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in. It sits between a requester issuing start/operand pulses and the shared 1-bit adder datapath. It trades latency for area by sequencing the cell LSB-first with a start/busy/done handshake.

## Interface

- WIDTH, 8, operand and result width in bits; legal range 1–32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on accepted start
- b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while an addition is in progress (RUN state)
- done  output  1  single-cycle pulse; sum/cout valid
- sum  output  WIDTH  registered result; held until next completion
- cout  output  1  registered carry-out; held until next completion

## Operation

- Internal state:
  - a_sh, b_sh: WIDTH-bit operand shift registers
  - acc: WIDTH-bit result shift register
  - c_reg: carry flop
  - cnt: bit counter, width clog2(WIDTH) with minimum 1
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at a rising edge: a_sh←a, b_sh←b, c_reg←cin, cnt←0, go to RUN.
  - On start=0: remain in IDLE.
- RUN, one bit per cycle:
  - Datapath: ha0 = half_add(a_sh[0], b_sh[0]); ha1 = half_add(ha0.s, c_reg).
  - Bit result: bit = ha1.s; carry_next = ha0.c | ha1.c.
  - Register updates: acc←{bit, acc[WIDTH-1:1]}; a_sh, b_sh shift right by 1; c_reg←carry_next; cnt←cnt+1.
  - When cnt==WIDTH-1: this is the last bit. On that edge, also load sum←final acc value (including this bit) and cout←carry_next, then go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE unconditionally.
- busy is registered and equals (state==RUN).
- start is ignored in RUN and DONE; no queuing. a, b and cin may change freely after acceptance.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- sum and cout change only on the edge entering DONE. Between operations they hold the previous result.
- WIDTH=1: RUN lasts one cycle (cnt==0 is the last bit).
- Reset (rst_n=0, any time, including mid-RUN):
  - State→IDLE.
  - busy, done, sum, cout, acc, a_sh, b_sh, c_reg and cnt all cleared to 0.
  - The in-flight operation is discarded and no done is produced.
  - After deassertion, the first start is accepted normally.

## Timing

- Edge 0: start accepted.
- Cycles 1..WIDTH: busy=1.
- Cycle WIDTH+1: done=1, busy=0, sum/cout valid.
- Cycle WIDTH+2: IDLE. Earliest next accept is at the edge ending cycle WIDTH+2.
- Latency from start edge to done: WIDTH+1 cycles. Throughput: one addition per WIDTH+2 cycles.
- All outputs are flop-driven; there are no combinational input→output paths.

## Structure

- Shared package adder_pkg holds:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default width constant ADD_W=8.
  - Helper clog2 function.
- Sub-module ha_cell (inputs a, b; outputs s = a^b, c = a&b), instantiated twice inside serial_add_seq to form the full-adder cell. This module is purely combinational.
- Everything else (FSM, counter, shift registers) lives in serial_add_seq.

## Test plan

All scenarios use WIDTH=8.

- Reset, then a=8'h00, b=8'h00, cin=0, start pulse → busy high cycles 1–8, done at cycle 9, sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1.
- a=8'h3C, b=8'h42, cin=0, with a/b changed to 8'hFF on the cycle after start → sum=8'h7E, cout=0 (operands were captured).
- Start held high continuously → accepts every 10 cycles. Start pulses during busy or done are ignored; exactly one done per accepted start.
- Assert rst_n=0 at cycle 4 of a run with a=8'h80, b=8'h80 → busy, done, sum and cout all 0 immediately, no done pulse. The next start with the same operands → sum=8'h00, cout=1.
- Sum hold: after the result 8'h7E, start a new addition. sum must stay 8'h7E through busy and change only on the new done cycle.
